md5_step_ctrl: RTL

- Sequencer for the combinational MD5 step datapath (the round1-style A/B/C/D step with F/G/H/I selection).
- Accepts one 512-bit message block plus a 128-bit chaining value.
- Holds the A/B/C/D working registers and drives the datapath for 64 steps, one step per clock.
- Adds the result back to the chaining value mod 2^32 and presents the 128-bit digest with a valid/ready handshake.

---
 rtl/md5_step_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/md5_step_ctrl.sv
// md5_step_ctrl: sequences one 512-bit block through an external MD5 step datapath (64 steps) and emits the chained 128-bit digest. Optional MD5_CHAIN_EN adds chain_sel to reuse the last digest as the IV.
module md5_step_ctrl #(
   parameter int NUM_STEPS = 64,
   parameter int WORD_W    = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_valid,
   output logic                  start_ready,
   input  logic [16*WORD_W-1:0]  msg_blk,
   input  logic [4*WORD_W-1:0]   iv_in,
`ifdef MD5_CHAIN_EN
   input  logic                  chain_sel,
`endif
   output logic [WORD_W-1:0]     dp_a,
   output logic [WORD_W-1:0]     dp_b,
   output logic [WORD_W-1:0]     dp_c,
   output logic [WORD_W-1:0]     dp_d,
   output logic [WORD_W-1:0]     dp_msg,
   output logic [4:0]            dp_shift,
   output logic [WORD_W-1:0]     dp_t,
   output logic [1:0]            dp_func,
   input  logic [WORD_W-1:0]     dp_aout,
   input  logic [WORD_W-1:0]     dp_bout,
   input  logic [WORD_W-1:0]     dp_cout,
   input  logic [WORD_W-1:0]     dp_dout,
   output logic [5:0]            step_idx,
   output logic                  busy,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*WORD_W-1:0]   digest
);
   typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;
   localparam logic [31:0] T_ROM [64] = '{
      32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
      32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
      32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
      32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
      32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
      32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
      32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
      32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
      32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
      32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
      32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
      32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
      32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
      32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
      32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
      32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
   };
   localparam logic [4:0] SHIFT_ROM [16] = '{
      5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9, 5'd14, 5'd20,
      5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
   };
   state_t               state, state_nxt;
   logic [WORD_W-1:0]    msg [16];
   logic [4*WORD_W-1:0]  chain;
   logic [4*WORD_W-1:0]  iv_src;
   logic [3:0]           i4;
   logic [3:0]           g;
`ifdef MD5_CHAIN_EN
   assign iv_src = chain_sel ? digest : iv_in;
`else
   assign iv_src = iv_in;
`endif
   assign i4 = step_idx[3:0];
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   // next state: accept in IDLE, leave RUN after the last step, one FINAL cycle, hold DONE until consumed
   always_comb
      state_nxt = (state == IDLE)  ? (start_valid ? RUN : IDLE) :
                  (state == RUN)   ? ((step_idx == 6'(NUM_STEPS - 1)) ? FINAL : RUN) :
                  (state == FINAL) ? DONE :
                  (out_ready ? IDLE : DONE);
   // handshake and status outputs decoded from the state
   always_comb begin
      start_ready = (state == IDLE);
      busy        = (state == RUN) || (state == FINAL);
      out_valid   = (state == DONE);
   end
   // per-step constants; step_idx stays 0 outside RUN so these show step 0 there
   always_comb begin
      g        = (step_idx[5:4] == 2'd0) ? i4 :
                 (step_idx[5:4] == 2'd1) ? i4 * 4'd5 + 4'd1 :
                 (step_idx[5:4] == 2'd2) ? i4 * 4'd3 + 4'd5 : i4 * 4'd7;
      dp_func  = step_idx[5:4];
      dp_shift = SHIFT_ROM[{step_idx[5:4], step_idx[1:0]}];
      dp_t     = T_ROM[step_idx];
      dp_msg   = msg[g];
   end
   // block capture, working-register update per step and final chaining add
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         step_idx <= '0;
         dp_a     <= '0;
         dp_b     <= '0;
         dp_c     <= '0;
         dp_d     <= '0;
         chain    <= '0;
         digest   <= '0;
         for (int k = 0; k < 16; k++) msg[k] <= '0;
      end else if (start_ready && start_valid) begin
         step_idx <= '0;
         chain    <= iv_src;
         dp_a     <= iv_src[31:0];
         dp_b     <= iv_src[63:32];
         dp_c     <= iv_src[95:64];
         dp_d     <= iv_src[127:96];
         for (int k = 0; k < 16; k++) msg[k] <= msg_blk[32*k +: 32];
      end else if (state == RUN) begin
         step_idx <= step_idx + 6'd1;
         dp_a     <= dp_aout;
         dp_b     <= dp_bout;
         dp_c     <= dp_cout;
         dp_d     <= dp_dout;
      end else if (state == FINAL)
         digest <= {chain[127:96] + dp_d, chain[95:64] + dp_c, chain[63:32] + dp_b, chain[31:0] + dp_a};
endmodule
